// File: rtl/digit_matrix_scroller.sv
// Loads a 4-digit BCD value, fills a 28-column glyph buffer from an
// external glyph ROM, and scans an 8-column scrolling window of that buffer
// onto an 8x8 LED matrix, one column at a time.
module digit_matrix_scroller #(
  parameter int unsigned SCAN_DIV      = 1000,
  parameter int unsigned SCROLL_FRAMES = 50
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        load,
  input  logic [15:0] digits,
  input  logic        scroll_en,
  output logic [3:0]  rom_digit,
  input  logic [7:0]  rom_col0,
  input  logic [7:0]  rom_col1,
  input  logic [7:0]  rom_col2,
  input  logic [7:0]  rom_col3,
  input  logic [7:0]  rom_col4,
  input  logic [7:0]  rom_col5,
  input  logic [7:0]  rom_col6,
  output logic        busy,
  output logic [7:0]  col_sel,
  output logic [7:0]  row_data
);

  localparam int unsigned NCOLS  = 28;
  localparam int unsigned GLYPHW = 7;
  localparam int unsigned DIV_W  = $clog2(SCAN_DIV);
  localparam int unsigned FRM_W  = $clog2(SCROLL_FRAMES + 1);
  localparam int unsigned OFF_W  = 5;

  typedef enum logic {IDLE, FILL} state_t;

  state_t              state, state_nxt;
  logic [1:0]          fill_idx, fill_idx_nxt;
  logic [15:0]         dig_q;
  logic [3:0]          rom_digit_nxt;
  logic                load_acc;
  logic [7:0]          buffer [NCOLS];
  logic [7:0]          glyph  [GLYPHW];
  logic [OFF_W-1:0]    fill_base;
  logic                blank;
  logic [DIV_W-1:0]    scan_cnt;
  logic [2:0]          scan_idx;
  logic                scan_tc;
  logic                frame_done;
  logic [FRM_W-1:0]    frame_cnt;
  logic [OFF_W-1:0]    offset;
  logic [5:0]          view_sum;
  logic [OFF_W-1:0]    view_idx;

  // Nibble of the captured value for a fill slot; slot 0 is the leftmost digit.
  function automatic logic [3:0] nib_of(input logic [15:0] d, input logic [1:0] idx);
    case (idx)
      2'd0:    nib_of = d[15:12];
      2'd1:    nib_of = d[11:8];
      2'd2:    nib_of = d[7:4];
      default: nib_of = d[3:0];
    endcase
  endfunction

  assign glyph[0] = rom_col0;
  assign glyph[1] = rom_col1;
  assign glyph[2] = rom_col2;
  assign glyph[3] = rom_col3;
  assign glyph[4] = rom_col4;
  assign glyph[5] = rom_col5;
  assign glyph[6] = rom_col6;

  assign fill_base  = OFF_W'(fill_idx) * OFF_W'(GLYPHW);
  assign blank      = (rom_digit > 4'd9);
  assign scan_tc    = (scan_cnt == DIV_W'(SCAN_DIV - 1));
  assign frame_done = scan_tc && (scan_idx == 3'd7);
  assign view_sum   = 6'(offset) + 6'(scan_idx);
  assign view_idx   = (view_sum >= 6'(NCOLS)) ? OFF_W'(view_sum - 6'(NCOLS)) : OFF_W'(view_sum);

  // Fill sequencer state register.
  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= IDLE;
      fill_idx <= 2'd0;
    end else begin
      state    <= state_nxt;
      fill_idx <= fill_idx_nxt;
    end
  end

  // Fill sequencer next state; rom_digit is lined up one cycle ahead of its slot.
  always_comb begin
    state_nxt     = state;
    fill_idx_nxt  = fill_idx;
    load_acc      = 1'b0;
    rom_digit_nxt = 4'd0;
    case (state)
      IDLE: begin
        if (load) begin
          load_acc      = 1'b1;
          state_nxt     = FILL;
          fill_idx_nxt  = 2'd0;
          rom_digit_nxt = digits[15:12];
        end
      end
      FILL: begin
        fill_idx_nxt = fill_idx + 2'd1;
        if (fill_idx == 2'd3) begin
          state_nxt = IDLE;
        end else begin
          rom_digit_nxt = nib_of(dig_q, fill_idx + 2'd1);
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  // Digit capture, ROM address, busy flag and glyph buffer writes.
  always_ff @(posedge clk) begin
    if (rst) begin
      dig_q     <= 16'd0;
      rom_digit <= 4'd0;
      busy      <= 1'b0;
      for (int i = 0; i < NCOLS; i++) buffer[i] <= 8'd0;
    end else begin
      rom_digit <= rom_digit_nxt;
      busy      <= (state_nxt == FILL);
      if (load_acc) dig_q <= digits;
      if (state == FILL) begin
        for (int c = 0; c < GLYPHW; c++) begin
          buffer[fill_base + OFF_W'(c)] <= blank ? 8'd0 : glyph[c];
        end
      end
    end
  end

  // Free-running column scan divider and column index.
  always_ff @(posedge clk) begin
    if (rst) begin
      scan_cnt <= '0;
      scan_idx <= 3'd0;
    end else if (scan_tc) begin
      scan_cnt <= '0;
      scan_idx <= scan_idx + 3'd1;
    end else begin
      scan_cnt <= scan_cnt + DIV_W'(1);
    end
  end

  // Scroll offset stepping; an accepted load restarts the window at column 0.
  always_ff @(posedge clk) begin
    if (rst || load_acc) begin
      frame_cnt <= '0;
      offset    <= '0;
    end else if (scroll_en && frame_done) begin
      if (frame_cnt == FRM_W'(SCROLL_FRAMES - 1)) begin
        frame_cnt <= '0;
        offset    <= (offset == OFF_W'(NCOLS - 1)) ? '0 : offset + OFF_W'(1);
      end else begin
        frame_cnt <= frame_cnt + FRM_W'(1);
      end
    end
  end

  // Registered panel drive; panel is blanked while the buffer is being filled.
  always_ff @(posedge clk) begin
    if (rst) begin
      col_sel  <= 8'd0;
      row_data <= 8'd0;
    end else begin
      col_sel  <= 8'd1 << scan_idx;
      row_data <= busy ? 8'd0 : buffer[view_idx];
    end
  end

endmodule

// File: tb/tb_digit_matrix_scroller.sv
// Scoreboard bench for digit_matrix_scroller: stimulus pushes expected ROM
// addresses, busy lengths and panel columns; a negedge monitor pops and compares.
module tb_digit_matrix_scroller;

  localparam int unsigned SCAN_DIV      = 2;
  localparam int unsigned SCROLL_FRAMES = 2;

  logic        clk = 1'b0;
  logic        rst;
  logic        load;
  logic [15:0] digits;
  logic        scroll_en;
  logic [3:0]  rom_digit;
  logic [7:0]  rom_col0, rom_col1, rom_col2, rom_col3, rom_col4, rom_col5, rom_col6;
  logic        busy;
  logic [7:0]  col_sel;
  logic [7:0]  row_data;
  logic [55:0] rom_word;

  typedef struct packed {
    logic [7:0] col;
    logic [7:0] row;
  } col_exp_t;

  col_exp_t   col_q [$];
  logic [3:0] rom_q [$];
  int         len_q [$];
  logic [7:0] exp_buf [28];

  int checks   = 0;
  int failures = 0;

  digit_matrix_scroller #(.SCAN_DIV(SCAN_DIV), .SCROLL_FRAMES(SCROLL_FRAMES)) dut (
    .clk(clk), .rst(rst), .load(load), .digits(digits), .scroll_en(scroll_en),
    .rom_digit(rom_digit),
    .rom_col0(rom_col0), .rom_col1(rom_col1), .rom_col2(rom_col2), .rom_col3(rom_col3),
    .rom_col4(rom_col4), .rom_col5(rom_col5), .rom_col6(rom_col6),
    .busy(busy), .col_sel(col_sel), .row_data(row_data)
  );

  always #5 clk = ~clk;

  // Glyph ROM stand-in: 7 columns, column 0 in the top byte; codes above 9 return 0xFF.
  function automatic logic [55:0] glyph_of(input logic [3:0] d);
    case (d)
      4'd0: glyph_of = 56'h00_3E_51_49_45_3E_00;
      4'd1: glyph_of = 56'h00_00_42_7F_40_00_00;
      4'd2: glyph_of = 56'h00_62_51_49_49_46_00;
      4'd3: glyph_of = 56'h00_22_41_49_49_36_00;
      4'd4: glyph_of = 56'h00_18_14_12_7F_10_00;
      4'd5: glyph_of = 56'h00_27_45_45_45_39_00;
      4'd6: glyph_of = 56'h00_3C_4A_49_49_30_00;
      4'd7: glyph_of = 56'h00_01_71_09_05_03_00;
      4'd8: glyph_of = 56'h00_36_49_49_49_36_00;
      4'd9: glyph_of = 56'h00_06_49_49_29_1E_00;
      default: glyph_of = 56'hFF_FF_FF_FF_FF_FF_FF;
    endcase
  endfunction

  assign rom_word = glyph_of(rom_digit);
  assign rom_col0 = rom_word[55:48];
  assign rom_col1 = rom_word[47:40];
  assign rom_col2 = rom_word[39:32];
  assign rom_col3 = rom_word[31:24];
  assign rom_col4 = rom_word[23:16];
  assign rom_col5 = rom_word[15:8];
  assign rom_col6 = rom_word[7:0];

  task automatic check(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Expected buffer contents for a BCD value (blank for invalid digits).
  task automatic build_buf(input logic [15:0] d);
    logic [3:0]  nib;
    logic [55:0] g;
    for (int i = 0; i < 4; i++) begin
      nib = d[15 - 4*i -: 4];
      g   = glyph_of(nib);
      for (int c = 0; c < 7; c++) begin
        exp_buf[7*i + c] = (nib > 4'd9) ? 8'h00 : g[55 - 8*c -: 8];
      end
    end
  endtask

  task automatic clear_buf();
    for (int i = 0; i < 28; i++) exp_buf[i] = 8'h00;
  endtask

  task automatic push_frame(input int off);
    col_exp_t e;
    for (int k = 0; k < 8; k++) begin
      e.col = 8'h01 << k;
      e.row = exp_buf[(off + k) % 28];
      col_q.push_back(e);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Return just after the scan wraps to column 0 (panel still shows column 7).
  task automatic sync_frame();
    int n;
    n = 0;
    while (col_sel != 8'h40 && n < 100) begin tick(); n++; end
    while (col_sel != 8'h80 && n < 100) begin tick(); n++; end
    if (n >= 100) begin
      checks++;
      failures++;
      $display("FAIL sync_frame: col_sel stuck at 0x%0h", col_sel);
    end
    tick();
  endtask

  task automatic drain(input int limit);
    int n;
    n = 0;
    while ((col_q.size() != 0 || rom_q.size() != 0 || len_q.size() != 0) && n < limit) begin
      tick();
      n++;
    end
    if (n >= limit) begin
      checks++;
      failures++;
      $display("FAIL drain_timeout: pending col=%0d rom=%0d len=%0d",
               col_q.size(), rom_q.size(), len_q.size());
      col_q.delete();
      rom_q.delete();
      len_q.delete();
    end
  endtask

  task automatic do_load(input logic [15:0] d, input bit glitch);
    load   = 1'b1;
    digits = d;
    tick();
    load   = 1'b0;
    digits = 16'hFFFF;
    tick();
    if (glitch) begin
      load   = 1'b1;
      digits = 16'h5678;
      tick();
      load   = 1'b0;
    end
  endtask

  // Monitor: compares ROM address each busy cycle, busy run length, and each new panel column.
  logic       prev_busy = 1'b0;
  logic [7:0] prev_col  = 8'h00;
  int         run       = 0;
  always @(negedge clk) begin
    col_exp_t e;
    logic [3:0] r;
    int l;
    if (busy === 1'b1) begin
      run++;
      if (rom_q.size() == 0) begin
        check("unexpected_busy", 1, 0);
      end else begin
        r = rom_q.pop_front();
        check("rom_digit", int'(rom_digit), int'(r));
      end
    end else if (prev_busy) begin
      if (len_q.size() == 0) begin
        check("unexpected_busy_end", run, 0);
      end else begin
        l = len_q.pop_front();
        check("busy_cycles", run, l);
      end
      run = 0;
    end
    prev_busy = (busy === 1'b1);
    if (col_sel !== prev_col) begin
      if (col_q.size() != 0) begin
        e = col_q.pop_front();
        check("col_sel", int'(col_sel), int'(e.col));
        check("row_data", int'(row_data), int'(e.row));
      end
      prev_col = col_sel;
    end
  end

  initial begin
    int off;
    rst       = 1'b1;
    load      = 1'b0;
    digits    = 16'h0000;
    scroll_en = 1'b0;

    // Reset state, then a blank scan frame after release.
    repeat (3) tick();
    check("reset_col_sel", int'(col_sel), 0);
    check("reset_row_data", int'(row_data), 0);
    check("reset_busy", int'(busy), 0);
    check("reset_rom_digit", int'(rom_digit), 0);
    clear_buf();
    push_frame(0);
    rst = 1'b0;
    drain(200);

    // Load 1234 with a second load pulse during the fill.
    build_buf(16'h1234);
    rom_q.push_back(4'd1); rom_q.push_back(4'd2); rom_q.push_back(4'd3); rom_q.push_back(4'd4);
    len_q.push_back(4);
    do_load(16'h1234, 1'b1);
    drain(100);
    sync_frame();
    push_frame(0);
    drain(100);

    // Scroll through all 28 offsets with a 5-frame hold at offset 27.
    sync_frame();
    scroll_en = 1'b1;
    for (int f = 0; f < 62; f++) begin
      if (f <= 54)      off = f / 2;
      else if (f <= 60) off = 27;
      else              off = 0;
      push_frame(off);
    end
    repeat (872) tick();
    scroll_en = 1'b0;
    repeat (80) tick();
    scroll_en = 1'b1;
    drain(400);
    scroll_en = 1'b0;

    // Invalid leading digit blanks its columns.
    build_buf(16'hA000);
    rom_q.push_back(4'hA); rom_q.push_back(4'd0); rom_q.push_back(4'd0); rom_q.push_back(4'd0);
    len_q.push_back(4);
    do_load(16'hA000, 1'b0);
    drain(100);
    sync_frame();
    push_frame(0);
    drain(100);

    // Reset while the third digit is being fetched.
    rom_q.push_back(4'd1); rom_q.push_back(4'd2); rom_q.push_back(4'd3);
    len_q.push_back(3);
    load   = 1'b1;
    digits = 16'h1234;
    tick();
    load = 1'b0;
    tick();
    tick();
    rst = 1'b1;
    tick();
    check("midfill_busy", int'(busy), 0);
    check("midfill_rom_digit", int'(rom_digit), 0);
    check("midfill_col_sel", int'(col_sel), 0);
    check("midfill_row_data", int'(row_data), 0);
    tick();
    clear_buf();
    push_frame(0);
    rst = 1'b0;
    drain(200);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
